// File: rtl/frame_diff_pkg.sv
// Shared types and helpers for the frame diff scanner.
package frame_diff_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SCAN      = 2'd1,
    WAIT_CMD  = 2'd2,
    FRAME_END = 2'd3
  } state_t;

  localparam int CODE_BG = 0;

  // Coordinate width; a one-tile axis still needs a one-bit counter.
  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/obj_priority_enc.sv
// Combinational priority encoder: object index 0 wins, code = index+1, 0 = background.
module obj_priority_enc
  import frame_diff_pkg::*;
#(
  parameter int OBJ_N  = 4,
  parameter int CODE_W = 3
) (
  input  logic [OBJ_N-1:0]  obj_hit,
  output logic [CODE_W-1:0] code
);

  if ((2 ** CODE_W) <= OBJ_N) begin : g_code_w_check
    $error("obj_priority_enc: CODE_W too small to encode OBJ_N objects plus background");
  end

  // Scan from lowest priority upward so the highest-priority hit is written last.
  always_comb begin
    code = CODE_W'(CODE_BG);
    for (int i = OBJ_N - 1; i >= 0; i--) begin
      if (obj_hit[i]) code = CODE_W'(i + 1);
    end
  end

endmodule

// File: rtl/frame_diff_scanner.sv
// Raster scan of the tile grid, emitting changed cells to the display command engine.
// Optional draw counter output enabled by defining FRAME_DIFF_STATS_EN.
//
// state     | meaning
// IDLE      | waiting for update_tick or a forced redraw
// SCAN      | one cell per cycle, compare against the stored frame
// WAIT_CMD  | diff issued, holding the cell until cmd_done
// FRAME_END | last cell done, pulse frame_done
module frame_diff_scanner
  import frame_diff_pkg::*;
#(
  parameter int GRID_W = 16,
  parameter int GRID_H = 12,
  parameter int OBJ_N  = 4,
  parameter int CODE_W = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [OBJ_N-1:0]                obj_hit,
  input  logic                            update_tick,
  input  logic                            cmd_done,
  input  logic                            game_over,
  input  logic                            mode_pb,
  output logic [coord_w(GRID_W)-1:0]      x,
  output logic [coord_w(GRID_H)-1:0]      y,
  output logic [CODE_W-1:0]               obj_code,
  output logic                            diff,
  output logic                            enable_loop,
  output logic                            init_cycle,
  output logic                            frame_done,
  output logic                            sync_reset
`ifdef FRAME_DIFF_STATS_EN
  ,
  output logic [$clog2(GRID_W*GRID_H+1)-1:0] draw_count
`endif
);

  localparam int XW    = coord_w(GRID_W);
  localparam int YW    = coord_w(GRID_H);
  localparam int CELLS = GRID_W * GRID_H;
  localparam int IDXW  = coord_w(CELLS);

  state_t              r_state;
  logic [XW-1:0]       r_x;
  logic [YW-1:0]       r_y;
  logic [CODE_W-1:0]   r_obj_code;
  logic                r_diff;
  logic                r_init;
  logic                r_sync_reset;
  logic                r_restart_pend;
  logic                r_go_d;
  logic                r_pb_d;
  logic [CODE_W-1:0]   r_map [CELLS];

  logic [CODE_W-1:0]   w_code;
  logic [CODE_W-1:0]   w_map_code;
  logic [IDXW-1:0]     w_idx;
  logic                w_last_x;
  logic                w_last_cell;
  logic [XW-1:0]       w_x_next;
  logic [YW-1:0]       w_y_next;
  logic                w_restart_edge;
  logic                w_take_restart;
  logic                w_map_we;

  obj_priority_enc #(
    .OBJ_N  (OBJ_N),
    .CODE_W (CODE_W)
  ) u_enc (
    .obj_hit (obj_hit),
    .code    (w_code)
  );

  assign w_idx       = IDXW'(int'(r_y) * GRID_W + int'(r_x));
  assign w_map_code  = r_map[w_idx];
  assign w_last_x    = (r_x == XW'(GRID_W - 1));
  assign w_last_cell = w_last_x && (r_y == YW'(GRID_H - 1));
  assign w_x_next    = w_last_x ? '0 : r_x + 1'b1;
  assign w_y_next    = w_last_x ? r_y + 1'b1 : r_y;

  assign w_restart_edge = (game_over & ~r_go_d) | (mode_pb & ~r_pb_d);

  // A restart seen during WAIT_CMD waits for the display transaction to finish.
  always_comb begin
    w_take_restart = 1'b0;
    unique case (r_state)
      IDLE, SCAN, FRAME_END: w_take_restart = w_restart_edge;
      WAIT_CMD:              w_take_restart = cmd_done & (w_restart_edge | r_restart_pend);
      default:               w_take_restart = 1'b0;
    endcase
  end

  assign w_map_we = (r_state == SCAN) && !w_take_restart && (r_init || (w_code != w_map_code));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_x            <= '0;
      r_y            <= '0;
      r_obj_code     <= CODE_W'(CODE_BG);
      r_diff         <= 1'b0;
      r_init         <= 1'b1;
      r_sync_reset   <= 1'b0;
      r_restart_pend <= 1'b0;
      r_go_d         <= 1'b0;
      r_pb_d         <= 1'b0;
    end else begin
      r_go_d       <= game_over;
      r_pb_d       <= mode_pb;
      r_diff       <= 1'b0;
      r_sync_reset <= 1'b0;
      if (w_take_restart) begin
        r_sync_reset   <= 1'b1;
        r_init         <= 1'b1;
        r_x            <= '0;
        r_y            <= '0;
        r_restart_pend <= 1'b0;
        r_state        <= IDLE;
      end else begin
        unique case (r_state)
          IDLE: begin
            r_x <= '0;
            r_y <= '0;
            if (update_tick || r_init) r_state <= SCAN;
          end
          SCAN: begin
            if (w_map_we) begin
              r_obj_code <= w_code;
              r_diff     <= 1'b1;
              r_state    <= WAIT_CMD;
            end else if (w_last_cell) begin
              r_state <= FRAME_END;
            end else begin
              r_x <= w_x_next;
              r_y <= w_y_next;
            end
          end
          WAIT_CMD: begin
            if (cmd_done) begin
              if (w_last_cell) begin
                r_state <= FRAME_END;
              end else begin
                r_x     <= w_x_next;
                r_y     <= w_y_next;
                r_state <= SCAN;
              end
            end else if (w_restart_edge) begin
              r_restart_pend <= 1'b1;
            end
          end
          FRAME_END: begin
            r_init  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  // Frame map is intentionally unreset; init_cycle forces a full redraw instead.
  always_ff @(posedge clk) begin
    if (w_map_we) r_map[w_idx] <= w_code;
  end

  assign x           = r_x;
  assign y           = r_y;
  assign obj_code    = r_obj_code;
  assign diff        = r_diff;
  assign init_cycle  = r_init;
  assign sync_reset  = r_sync_reset;
  assign enable_loop = (r_state == SCAN) || (r_state == WAIT_CMD);
  assign frame_done  = (r_state == FRAME_END) && !w_take_restart;

`ifdef FRAME_DIFF_STATS_EN
  localparam int DCW = $clog2(CELLS + 1);

  logic [DCW-1:0] r_draw_run;
  logic [DCW-1:0] r_draw_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_draw_run   <= '0;
      r_draw_count <= '0;
    end else if (w_take_restart) begin
      r_draw_run <= '0;
    end else if (frame_done) begin
      r_draw_count <= r_draw_run;
      r_draw_run   <= '0;
    end else if (w_map_we) begin
      r_draw_run <= r_draw_run + 1'b1;
    end
  end

  assign draw_count = r_draw_count;
`endif

endmodule

// File: tb/tb_frame_diff_scanner.sv
// Self-checking bench for frame_diff_scanner: scene model drives obj_hit, scoreboard checks every diff.
module tb_frame_diff_scanner;

  localparam int GW    = 16;
  localparam int GH    = 12;
  localparam int CELLS = GW * GH;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] obj_hit;
  logic       update_tick, cmd_done, game_over, mode_pb;
  logic [3:0] x, y;
  logic [2:0] obj_code;
  logic       diff, enable_loop, init_cycle, frame_done, sync_reset;

  typedef struct packed {
    logic [3:0] x;
    logic [3:0] y;
    logic [2:0] code;
  } draw_t;

  typedef struct {
    logic [3:0] hit;
    logic [2:0] code;
  } prio_vec_t;

  logic [3:0] scene    [CELLS];
  logic [2:0] exp_map  [CELLS];
  logic       logged   [CELLS];
  logic [2:0] log_code [CELLS];
  draw_t      exp_q[$];
  prio_vec_t  prio_tbl [16];

  int n_cmp = 0;
  int n_err = 0;
  int cyc_no = 0;
  int diff_cnt, fd_cnt, sr_cnt, first_scan, last_fd;
  int cmd_timer = 0;
  bit cmd_auto = 1'b1;

  always #5 clk = ~clk;

  assign obj_hit = scene[int'(y) * GW + int'(x)];

  frame_diff_scanner #(
    .GRID_W (GW),
    .GRID_H (GH),
    .OBJ_N  (4),
    .CODE_W (3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .obj_hit     (obj_hit),
    .update_tick (update_tick),
    .cmd_done    (cmd_done),
    .game_over   (game_over),
    .mode_pb     (mode_pb),
    .x           (x),
    .y           (y),
    .obj_code    (obj_code),
    .diff        (diff),
    .enable_loop (enable_loop),
    .init_cycle  (init_cycle),
    .frame_done  (frame_done),
    .sync_reset  (sync_reset)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc_no);
    end
  endtask

  function automatic logic [2:0] model_code(input logic [3:0] h);
    for (int i = 0; i < 4; i++) if (h[i]) return 3'(i + 1);
    return 3'd0;
  endfunction

  task automatic push_frame(input bit init);
    logic [2:0] c;
    for (int i = 0; i < CELLS; i++) begin
      c = model_code(scene[i]);
      if (init || c != exp_map[i]) exp_q.push_back(draw_t'({4'(i % GW), 4'(i / GW), c}));
      exp_map[i] = c;
    end
  endtask

  task automatic clear_log();
    diff_cnt = 0; fd_cnt = 0; sr_cnt = 0; first_scan = -1; last_fd = -1;
    for (int i = 0; i < CELLS; i++) begin
      logged[i] = 1'b0;
      log_code[i] = 3'd0;
    end
  endtask

  task automatic cyc();
    int    idx;
    draw_t e;
    @(negedge clk);
    cyc_no++;
    if (diff) begin
      idx = int'(y) * GW + int'(x);
      diff_cnt++;
      logged[idx] = 1'b1;
      log_code[idx] = obj_code;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_diff: got cell (%0d,%0d) code %0d, expected no draw", x, y, obj_code);
      end else begin
        e = exp_q.pop_front();
        check("diff_cell_xy_code", 32'({x, y, obj_code}), 32'(e));
      end
      if (cmd_auto) cmd_timer = 5;
    end
    if (frame_done) begin
      fd_cnt++;
      last_fd = cyc_no;
    end
    if (sync_reset) sr_cnt++;
    if (enable_loop && first_scan < 0) first_scan = cyc_no;
    if (cmd_auto) begin
      cmd_done = 1'b0;
      if (cmd_timer > 0) begin
        cmd_timer--;
        if (cmd_timer == 0) cmd_done = 1'b1;
      end
    end
  endtask

  task automatic run_frame(input int budget);
    for (int i = 0; i < budget && fd_cnt == 0; i++) cyc();
    check("frame_done_seen", 32'(fd_cnt > 0), 32'd1);
    repeat (2) cyc();
    check("frame_done_pulses", 32'(fd_cnt), 32'd1);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic tick();
    update_tick = 1'b1;
    cyc();
    update_tick = 1'b0;
  endtask

  initial begin
    prio_tbl[0]  = '{4'b0101, 3'd1};
    prio_tbl[1]  = '{4'b0000, 3'd0};
    prio_tbl[2]  = '{4'b0001, 3'd1};
    prio_tbl[3]  = '{4'b0010, 3'd2};
    prio_tbl[4]  = '{4'b0011, 3'd1};
    prio_tbl[5]  = '{4'b0100, 3'd3};
    prio_tbl[6]  = '{4'b0110, 3'd2};
    prio_tbl[7]  = '{4'b0111, 3'd1};
    prio_tbl[8]  = '{4'b1000, 3'd4};
    prio_tbl[9]  = '{4'b1001, 3'd1};
    prio_tbl[10] = '{4'b1010, 3'd2};
    prio_tbl[11] = '{4'b1011, 3'd1};
    prio_tbl[12] = '{4'b1100, 3'd3};
    prio_tbl[13] = '{4'b1101, 3'd1};
    prio_tbl[14] = '{4'b1110, 3'd2};
    prio_tbl[15] = '{4'b1111, 3'd1};

    rst = 1'b1; update_tick = 1'b0; cmd_done = 1'b0; game_over = 1'b0; mode_pb = 1'b0;
    for (int i = 0; i < CELLS; i++) begin
      scene[i] = 4'd0;
      exp_map[i] = 3'd0;
    end
    clear_log();
    repeat (3) cyc();
    check("reset_outputs", 32'({x, y, obj_code, diff, enable_loop, init_cycle, frame_done, sync_reset}),
          32'({4'd0, 4'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}));

    // Let an init frame get going, then reset in the middle of it.
    push_frame(1'b1);
    rst = 1'b0;
    repeat (40) cyc();
    rst = 1'b1; exp_q.delete(); cmd_timer = 0; cmd_done = 1'b0;
    cyc();
    check("midframe_reset", 32'({x, y, diff, init_cycle, enable_loop}), 32'({4'd0, 4'd0, 1'b0, 1'b1, 1'b0}));
    clear_log();
    push_frame(1'b1);
    rst = 1'b0;
    cyc();
    check("scan_after_reset", 32'(enable_loop), 32'd1);
    run_frame(3000);
    check("init_diff_count", 32'(diff_cnt), 32'd192);
    check("init_cycle_cleared", 32'(init_cycle), 32'd0);

    // Static frame: no draws, exactly one cell per SCAN cycle.
    clear_log(); push_frame(1'b0); tick(); run_frame(400);
    check("static_diff_count", 32'(diff_cnt), 32'd0);
    check("static_frame_len", 32'(last_fd - first_scan), 32'd192);

    // Priority table laid out across row 0.
    for (int i = 0; i < 16; i++) scene[i] = prio_tbl[i].hit;
    clear_log(); push_frame(1'b0); tick(); run_frame(800);
    for (int i = 0; i < 16; i++)
      check($sformatf("prio_x%0d", i), 32'({logged[i], log_code[i]}),
            32'({prio_tbl[i].code != 3'd0, prio_tbl[i].code}));
    check("prio_diff_count", 32'(diff_cnt), 32'd15);

    // Object appears at (4,4), then moves to (5,4).
    scene[4*GW+4] = 4'b0010;
    clear_log(); push_frame(1'b0); tick(); run_frame(400);
    check("place_diff_count", 32'(diff_cnt), 32'd1);
    scene[4*GW+4] = 4'b0000;
    scene[4*GW+5] = 4'b0010;
    clear_log(); push_frame(1'b0); tick(); run_frame(400);
    check("move_diff_count", 32'(diff_cnt), 32'd2);
    check("move_codes", 32'({logged[4*GW+4], log_code[4*GW+4], logged[4*GW+5], log_code[4*GW+5]}),
          32'({1'b1, 3'd0, 1'b1, 3'd2}));

    // Restart while waiting on the display at (7,4).
    scene[4*GW+7] = 4'b1000;
    clear_log(); push_frame(1'b0);
    cmd_auto = 1'b0;
    tick();
    for (int i = 0; i < 400 && diff_cnt == 0; i++) cyc();
    check("wait_cell", 32'({x, y}), 32'({4'd7, 4'd4}));
    game_over = 1'b1;
    repeat (3) cyc();
    check("no_sync_before_done", 32'(sr_cnt), 32'd0);
    check("held_in_wait", 32'(enable_loop), 32'd1);
    cmd_done = 1'b1;
    cyc();
    cmd_done = 1'b0;
    check("restart_taken", 32'({sync_reset, x, y, init_cycle}), 32'({1'b1, 4'd0, 4'd0, 1'b1}));
    check("restart_queue_empty", 32'(exp_q.size()), 32'd0);
    game_over = 1'b0;
    clear_log(); push_frame(1'b1);
    cmd_auto = 1'b1;
    run_frame(3000);
    check("redraw_diff_count", 32'(diff_cnt), 32'd192);
    check("redraw_cell0_prio", 32'(log_code[0]), 32'd1);
    check("redraw_init_cleared", 32'(init_cycle), 32'd0);

    // mode_pb restart during a plain SCAN, then a dropped update_tick mid redraw.
    clear_log(); push_frame(1'b0); tick();
    repeat (20) cyc();
    mode_pb = 1'b1;
    cyc();
    check("pb_restart_taken", 32'({sync_reset, x, y, init_cycle}), 32'({1'b1, 4'd0, 4'd0, 1'b1}));
    check("pb_no_frame_done", 32'(fd_cnt), 32'd0);
    mode_pb = 1'b0;
    clear_log(); push_frame(1'b1);
    repeat (50) cyc();
    tick();
    run_frame(3000);
    check("pb_redraw_diff_count", 32'(diff_cnt), 32'd192);
    repeat (5) cyc();
    check("tick_dropped_idle", 32'(enable_loop), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
